// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset fetch address and the
// fetch entry layout carried from the fetch front end to decode.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear, occupancy count and a head word
// that is always visible on head_o (no read latency).
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             full;

  // Popping an empty FIFO is ignored so callers need not gate pop_i.
  assign do_pop  = pop_i && (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage: write the pushed word at the write pointer. A push and pop on a
  // full FIFO reuse the head slot, which is safe because the head moves on.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i && !rst) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The producer must never push into a full FIFO unless the head leaves too.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr_i)
    !(push_i && !do_pop && full));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: drives the code ROM address, captures the word
// returned one cycle later, buffers {pc, word} pairs and hands them to decode
// over a valid/ready handshake. A redirect flushes everything and restarts.
module ifetch_queue
  import cpu_pkg::XLEN;
#(
  parameter int                ADDR_W   = XLEN,
  parameter int                DATA_W   = XLEN,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] code_addr,
  input  logic [DATA_W-1:0] code_data,
  input  logic              code_rdl,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              head_valid;
  logic              drop;
  logic              issue;
  logic [CNT_W:0]    occupancy;

  // Words already buffered plus the one still in flight from the ROM.
  assign occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(pend_q);
  assign head_valid = (fifo_count != '0);

  // A lost response replays its address; a same-cycle issue is suppressed so
  // the ROM answer for the following address is never mistaken for this one.
  assign drop       = pend_q && !code_rdl;
  assign issue      = !redirect_en && !drop && (occupancy < (CNT_W + 1)'(DEPTH));

  // Redirect discards the in-flight word and voids any pop in the same cycle.
  assign fifo_push  = pend_q && code_rdl && !redirect_en;
  assign fifo_pop   = head_valid && inst_ready && !redirect_en;

  // Next fetch address and in-flight tracking: redirect, then replay, then issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      pend_d     = 1'b0;
    end else if (drop) begin
      fetch_pc_d = pend_pc_q;
      pend_d     = 1'b0;
    end else begin
      pend_d = issue;
      if (issue) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      pend_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (redirect_en),
    .push_i      (fifo_push),
    .push_data_i ({pend_pc_q, code_data}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Outputs come straight from registers; an empty queue presents zeros.
  assign code_addr  = fetch_pc_q;
  assign inst_valid = head_valid;
  assign inst_pc    = head_valid ? fifo_head[ENT_W-1:DATA_W] : '0;
  assign inst_data  = head_valid ? fifo_head[DATA_W-1:0]     : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a ROM model answers every address one cycle later,
// a scoreboard holds the in-order {pc, word} stream expected since the last
// reset/redirect, and a monitor compares every accepted handshake.
`timescale 1ns/1ps
module tb_ifetch_queue;
  import cpu_pkg::*;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] START_PC = 32'h0;
  localparam logic [31:0] ROM_BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] code_addr;
  logic [DW-1:0] code_data;
  logic          code_rdl = 1'b1;
  logic          redirect_en = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b1;

  int checks   = 0;
  int failures = 0;
  int n_pops   = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (START_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code_addr   (code_addr),
    .code_data   (code_data),
    .code_rdl    (code_rdl),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return ROM_BASE + a;
  endfunction

  // ROM: samples code_addr at the edge; when not ready it returns junk.
  logic [31:0] rom_word_q;
  logic [31:0] junk_q;
  always @(posedge clk) begin
    rom_word_q <= rom_word(code_addr);
    junk_q     <= $urandom;
  end
  assign code_data = code_rdl ? rom_word_q : junk_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected stream after a restart: consecutive addresses, wrapping at 2^32.
  task automatic load_stream(input logic [31:0] start);
    fetch_entry_t e;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc    = start + 32'(i);
      e.instr = rom_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Stimulus side of the scoreboard: each reset/redirect restarts the stream.
  always @(posedge clk) begin
    if (rst) load_stream(START_PC);
    else if (redirect_en) load_stream(redirect_pc);
  end

  // Monitor: a handshake that will complete at the next edge consumes one entry.
  always @(negedge clk) begin
    if (!rst && !redirect_en && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_extra: got pc %0h, no word expected", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_pc", 64'(inst_pc), 64'(mon_e.pc));
        check("stream_data", 64'(inst_data), 64'(mon_e.instr));
        n_pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_code_addr(input logic [31:0] a);
    int n = 0;
    while (code_addr !== a && n < 20) begin
      tick();
      n++;
    end
    check("wait_code_addr", 64'(code_addr), 64'(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr_a;
    int since;
    int pops_before;

    // 1. Reset values and start-up latency
    repeat (3) tick();
    check("rst_code_addr", 64'(code_addr), 64'(START_PC));
    check("rst_valid", 64'(inst_valid), 0);
    check("rst_data", 64'(inst_data), 0);
    check("rst_pc", 64'(inst_pc), 0);
    rst = 1'b0;
    tick();
    check("lat1_valid", 64'(inst_valid), 0);
    check("lat1_code_addr", 64'(code_addr), 1);
    tick();
    check("lat2_valid", 64'(inst_valid), 1);
    check("lat2_pc", 64'(inst_pc), 0);
    check("lat2_data", 64'(inst_data), 64'(ROM_BASE));
    check("lat2_code_addr", 64'(code_addr), 2);

    // 3. Lost ROM response for PC 5 is replayed
    wait_code_addr(32'd5);
    tick();
    code_rdl = 1'b0;
    tick();
    check("replay_code_addr", 64'(code_addr), 5);
    code_rdl = 1'b1;
    repeat (8) tick();

    // 2. Decode stalls for 10 cycles: buffer fills to DEPTH and fetch stops
    inst_ready = 1'b0;
    repeat (8) tick();
    addr_a = code_addr;
    repeat (2) tick();
    check("stall_addr_frozen", 64'(code_addr), 64'(addr_a));
    check("stall_buffered", 64'(code_addr - inst_pc), DEPTH);
    check("stall_valid", 64'(inst_valid), 1);
    inst_ready = 1'b1;
    repeat (10) tick();

    // 4. Redirect with 3 buffered words and one in flight
    inst_ready  = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_en = 1'b0;
    repeat (4) tick();
    check("t4_head_pc", 64'(inst_pc), 64'h20);
    check("t4_code_addr", 64'(code_addr), 64'h24);
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    inst_ready  = 1'b1;
    tick();
    redirect_en = 1'b0;
    check("t4_valid_drop", 64'(inst_valid), 0);
    tick();
    check("t4_valid_c2", 64'(inst_valid), 0);
    tick();
    check("t4_valid_c3", 64'(inst_valid), 1);
    check("t4_first_pc", 64'(inst_pc), 64'h40);
    repeat (6) tick();

    // 5. Redirect on a full FIFO with ready high, then reset mid-stream
    inst_ready = 1'b0;
    repeat (8) tick();
    check("t5_full_valid", 64'(inst_valid), 1);
    check("t5_full_depth", 64'(code_addr - inst_pc), DEPTH);
    redirect_en = 1'b1;
    redirect_pc = 32'h80;
    inst_ready  = 1'b1;
    tick();
    redirect_en = 1'b0;
    check("t5_valid_drop", 64'(inst_valid), 0);
    repeat (2) tick();
    check("t5_valid_back", 64'(inst_valid), 1);
    check("t5_first_pc", 64'(inst_pc), 64'h80);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t5_rst_code_addr", 64'(code_addr), 64'(START_PC));
    check("t5_rst_valid", 64'(inst_valid), 0);
    check("t5_rst_pc", 64'(inst_pc), 0);
    check("t5_rst_data", 64'(inst_data), 0);
    rst = 1'b0;
    repeat (2) tick();
    check("t5_restart_valid", 64'(inst_valid), 1);
    check("t5_restart_pc", 64'(inst_pc), 64'(START_PC));
    repeat (4) tick();

    // 6. PC wrap-around
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_en = 1'b0;
    repeat (2) tick();
    check("wrap_valid", 64'(inst_valid), 1);
    check("wrap_pc0", 64'(inst_pc), 64'hFFFF_FFFE);
    tick();
    check("wrap_pc1", 64'(inst_pc), 64'hFFFF_FFFF);
    tick();
    check("wrap_pc2", 64'(inst_pc), 0);
    tick();
    check("wrap_pc3", 64'(inst_pc), 1);
    check("wrap_data3", 64'(inst_data), 64'(rom_word(32'd1)));

    // Randomized traffic: ready, ROM readiness, redirects and resets
    since       = 0;
    pops_before = n_pops;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      code_rdl   = ($urandom_range(0, 19) < 17);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rnd_rst_addr", 64'(code_addr), 64'(START_PC));
        check("rnd_rst_valid", 64'(inst_valid), 0);
        since = 0;
      end else if ($urandom_range(0, 39) == 0 || since >= 120) begin
        redirect_en = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ?
                      32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom);
        tick();
        redirect_en = 1'b0;
        check("rnd_redir_valid", 64'(inst_valid), 0);
        check("rnd_redir_addr", 64'(code_addr), 64'(redirect_pc));
        since = 0;
      end else begin
        tick();
        since++;
      end
    end
    inst_ready = 1'b1;
    code_rdl   = 1'b1;
    repeat (10) tick();
    check("rnd_throughput_ok", 64'((n_pops - pops_before) >= 500), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
